// File: rtl/mips_mem_pkg.sv
// Shared definitions for the M-stage load/store path of the MIPS core.
// Holds the memory op-code encoding, the LSU state encoding and small
// classification helpers (load/store/legal, alignment check) used by both
// the LSU control and the lane-steering datapath.
package mips_mem_pkg;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LHU = 4'd2;
    localparam logic [3:0] OP_LB  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic is_load(input logic [3:0] op);
        return (op <= OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_SB);
    endfunction

    // Natural alignment: words on 4 bytes, halves on 2, bytes anywhere.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            OP_LW, OP_SW:         bad = (addr_lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = addr_lo[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the data memory.
//   op_i      : memory op code
//   addr_lo_i : byte offset within the word
//   wdata_i   : raw store data (low bits for byte/half stores)
//   rdata_i   : word read from memory
//   be_o      : byte enables for the addressed lanes
//   wdata_o   : store data replicated across all lanes
//   load_o    : extracted and sign/zero-extended load result
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Bring the addressed byte down to lane 0; halves only ever sit at offset 0 or 2.
    assign shifted_s = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Per-op byte enables, store replication and load extension.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        load_o  = 32'h0000_0000;
        case (op_i)
            OP_LW, OP_SW: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                load_o  = rdata_i;
            end
            OP_LH, OP_LHU, OP_SH: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                if (op_i == OP_LH) begin
                    load_o = {{16{half_s[15]}}, half_s};
                end else begin
                    load_o = {16'h0000, half_s};
                end
            end
            OP_LB, OP_LBU, OP_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                if (op_i == OP_LB) begin
                    load_o = {{24{byte_s[7]}}, byte_s};
                end else begin
                    load_o = {24'h00_0000, byte_s};
                end
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = wdata_i;
                load_o  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// M-stage load/store initiator. Accepts one operation at a time in IDLE,
// faults illegal, misaligned or out-of-range accesses without touching
// memory, otherwise issues a single memory cycle, waits MEM_LATENCY cycles
// for loads, and returns a one-cycle response. Pipeline is stalled while busy.
//   clk, reset            : clock, synchronous active-high reset
//   req_*                 : operation from the pipeline (sampled only in IDLE)
//   resp_valid/rdata/exc  : completion pulse with load data or fault flag
//   stall                 : high whenever not IDLE
//   mem_*                 : word-addressed, byte-enabled data memory port
module dm_lsu
    import mips_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DEPTH_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0]  LAT_M1    = 4'(MEM_LATENCY - 1);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q, exc_d;

    logic        fault_s;
    logic        issue_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;
    logic [31:0] load_s;

    // Fault check on the raw request so the decision is made in the accept cycle.
    assign fault_s = !is_legal(req_op)
                   || is_misaligned(req_op, req_addr[1:0])
                   || ({2'b00, req_addr[31:2]} >= DEPTH_LIM);

    lsu_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (be_s),
        .wdata_o   (wdata_rep_s),
        .load_o    (load_s)
    );

    // Next-state and latch logic for the request FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    rdata_d = 32'h0000_0000;
                    exc_d   = fault_s;
                    state_d = fault_s ? ST_DONE : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = is_store(op_q) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // Counter reaching 0 marks the cycle mem_rdata is guaranteed valid.
                if (cnt_q == 4'd0) begin
                    rdata_d = load_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                rdata_d = 32'h0000_0000;
                exc_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            pc_q    <= 32'h0000_0000;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    // Reset gates the strobes directly so an ISSUE cycle caught by reset cannot write.
    assign issue_s    = (state_q == ST_ISSUE) && !reset;

    assign req_ready  = (state_q == ST_IDLE);
    assign stall      = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_rdata = rdata_q;
    assign resp_exc   = exc_q;

    assign mem_en     = issue_s;
    assign mem_we     = issue_s && is_store(op_q);
    assign mem_be     = issue_s ? be_s : 4'b0000;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_rep_s;

`ifndef SYNTHESIS
    // Store trace for simulation runs.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_ISSUE) && is_store(op_q)) begin
            $display("@%h: *%h <= %h", pc_q, mem_addr, mem_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: one instance with MEM_LATENCY=1 and one with
// MEM_LATENCY=3 share the request stimulus; each has its own read model that
// returns valid data only in the contracted cycle.
module tb_dm_lsu;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;

    logic        a_req_ready, a_resp_valid, a_resp_exc, a_stall, a_mem_en, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_be;
    logic        b_req_ready, b_resp_valid, b_resp_exc, b_stall, b_mem_en, b_mem_we;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          resp_cyc;
        logic        has_mem;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          issue_cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] mem [16];
    int          cnt_a = 0, cnt_b = 0;
    logic [3:0]  idx_a = 4'd0, idx_b = 4'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_lsu #(.MEM_LATENCY(1), .DEPTH_WORDS(3072)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_exc(a_resp_exc),
        .stall(a_stall), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dm_lsu #(.MEM_LATENCY(3), .DEPTH_WORDS(3072)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_exc(b_resp_exc),
        .stall(b_stall), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Read models: data valid only MEM_LATENCY cycles after the issue cycle.
    always @(posedge clk) begin
        if (a_mem_en && !a_mem_we) begin
            cnt_a <= 1;
            idx_a <= a_mem_addr[5:2];
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a + 1;
        end
        if (b_mem_en && !b_mem_we) begin
            cnt_b <= 1;
            idx_b <= b_mem_addr[5:2];
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b + 1;
        end
    end
    assign a_mem_rdata = (cnt_a == 1) ? mem[idx_a] : 32'hDEAD_BEEF;
    assign b_mem_rdata = (cnt_b == 3) ? mem[idx_b] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input int k, input logic rv, input logic [31:0] rd, input logic re,
                              input logic men, input logic mwe, input logic [31:0] maddr,
                              input logic [3:0] mbe, input logic [31:0] mwd);
        exp_t e;
        logic have;
        string p;
        p = (k == 0) ? "lat1" : "lat3";
        e = '{default: '0};
        have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
        if (have) begin
            if (k == 0) e = qa[0];
            else        e = qb[0];
        end
        if (men) begin
            chk({p, ".issue_slot"}, {31'b0, have && e.has_mem && (cyc == e.issue_cyc)}, 32'd1);
            chk({p, ".mem_addr"}, maddr, e.addr);
            chk({p, ".mem_we"}, {31'b0, mwe}, {31'b0, e.we});
            if (e.we) begin
                chk({p, ".mem_be"}, {28'b0, mbe}, {28'b0, e.be});
                chk({p, ".mem_wdata"}, mwd, e.wdata);
            end
        end else begin
            chk({p, ".idle_be"}, {28'b0, mbe}, 32'd0);
            chk({p, ".idle_we"}, {31'b0, mwe}, 32'd0);
        end
        if (rv) begin
            chk({p, ".resp_slot"}, {31'b0, have && (cyc == e.resp_cyc)}, 32'd1);
            chk({p, ".resp_rdata"}, rd, e.rdata);
            chk({p, ".resp_exc"}, {31'b0, re}, {31'b0, e.exc});
            if (have) begin
                if (k == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
            end
        end else begin
            chk({p, ".idle_rdata"}, rd, 32'd0);
            chk({p, ".idle_exc"}, {31'b0, re}, 32'd0);
            if (have && (cyc > e.resp_cyc)) begin
                chk({p, ".resp_missing"}, {31'b0, rv}, 32'd1);
                if (k == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
            end
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check_port(0, a_resp_valid, a_resp_rdata, a_resp_exc, a_mem_en, a_mem_we,
                       a_mem_addr, a_mem_be, a_mem_wdata);
            check_port(1, b_resp_valid, b_resp_rdata, b_resp_exc, b_mem_en, b_mem_we,
                       b_mem_addr, b_mem_be, b_mem_wdata);
        end
    end

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!(a_req_ready && b_req_ready) && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("ready_before_req", {31'b0, a_req_ready && b_req_ready}, 32'd1);
    endtask

    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_exc, input logic exp_we,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t e;
        int waited;
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0040_0000 + 32'(cyc * 4);
        e.rdata     = exp_rdata;
        e.exc       = exp_exc;
        e.has_mem   = !exp_exc;
        e.we        = exp_we;
        e.be        = exp_be;
        e.addr      = {addr[31:2], 2'b00};
        e.wdata     = exp_wdata;
        e.issue_cyc = cyc + 1;
        e.resp_cyc  = cyc + (exp_exc ? 1 : (exp_we ? 2 : 3));
        qa.push_back(e);
        e.resp_cyc  = cyc + (exp_exc ? 1 : (exp_we ? 2 : 5));
        qb.push_back(e);
        @(posedge clk); #2;
        // Scramble the request bus after accept; the DUT must ignore it.
        req_valid = 1'b0;
        req_op    = 4'hF;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_pc    = $urandom;
        waited = 0;
        while ((qa.size() > 0 || qb.size() > 0) && waited < 30) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("drain", 32'(qa.size() + qb.size()), 32'd0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'h8001_7FFF;
        mem[4]  = 32'hAB00_0000;
        mem[15] = 32'h0BAD_F00D;

        repeat (3) @(posedge clk);
        #2;
        chk("rst.req_ready", {30'b0, a_req_ready, b_req_ready}, 32'd3);
        chk("rst.stall", {30'b0, a_stall, b_stall}, 32'd0);
        chk("rst.resp_valid", {30'b0, a_resp_valid, b_resp_valid}, 32'd0);
        chk("rst.resp_rdata", a_resp_rdata | b_resp_rdata, 32'd0);
        chk("rst.resp_exc", {30'b0, a_resp_exc, b_resp_exc}, 32'd0);
        chk("rst.mem_strobes", {22'b0, a_mem_en, a_mem_we, a_mem_be, b_mem_en, b_mem_we, b_mem_be}, 32'd0);
        chk("rst.mem_addr", a_mem_addr | b_mem_addr, 32'd0);
        chk("rst.mem_wdata", a_mem_wdata | b_mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Stores: lane enables and replication.
        do_req(OP_SW, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h1234_5678);
        do_req(OP_SB, 32'h0000_0013, 32'h0000_00AB, 32'h0, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB);
        do_req(OP_SB, 32'h0000_0010, 32'hFFFF_FF5A, 32'h0, 1'b0, 1'b1, 4'b0001, 32'h5A5A_5A5A);
        do_req(OP_SH, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        do_req(OP_SH, 32'h0000_0010, 32'h1234_CAFE, 32'h0, 1'b0, 1'b1, 4'b0011, 32'hCAFE_CAFE);

        // Loads: extraction and extension.
        do_req(OP_LB,  32'h0000_0013, 32'h0, 32'hFFFF_FFAB, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LBU, 32'h0000_0013, 32'h0, 32'h0000_00AB, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LH,  32'h0000_0002, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LHU, 32'h0000_0002, 32'h0, 32'h0000_8001, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LH,  32'h0000_0000, 32'h0, 32'h0000_7FFF, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LB,  32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LB,  32'h0000_0001, 32'h0, 32'h0000_007F, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LBU, 32'h0000_0002, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LW,  32'h0000_0000, 32'h0, 32'h8001_7FFF, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(OP_LW,  32'h0000_2FFC, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 4'h0, 32'h0);

        // Faults: no memory access, exception one cycle after accept.
        do_req(OP_LW,  32'h0000_0006, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(OP_SH,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(4'd9,   32'h0000_0010, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(OP_LW,  32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(OP_LH,  32'h0000_0003, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(OP_SB,  32'h0000_3001, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);

        // Reset landing on the ISSUE cycle of a store.
        wait_ready();
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h5555_AAAA;
        @(posedge clk); #2;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_issue.mem_we", {30'b0, a_mem_we, b_mem_we}, 32'd0);
        chk("rst_issue.mem_en", {30'b0, a_mem_en, b_mem_en}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        chk("rst_issue.req_ready", {30'b0, a_req_ready, b_req_ready}, 32'd3);
        chk("rst_issue.stall", {30'b0, a_stall, b_stall}, 32'd0);
        chk("rst_issue.resp_valid", {30'b0, a_resp_valid, b_resp_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #2;

        // Normal operation resumes after the interrupted store.
        do_req(OP_SW, 32'h0000_0024, 32'hC0FF_EE00, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hC0FF_EE00);
        do_req(OP_LW, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 1'b0, 1'b0, 4'h0, 32'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store initiator for the M stage of the pipelined MIPS core. It accepts one memory operation at a time from the pipeline and checks alignment and range. It drives the word-addressed, byte-enabled data memory with a fixed read latency, then returns an extended load result or an exception flag. While an operation is in flight it holds the pipeline via `stall`.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from the memory issue cycle to valid `mem_rdata`; legal range 1..15.
- `DEPTH_WORDS`, default 3072: number of words in data memory; word index = `addr[31:2]`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: pipeline presents an operation.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_op` in 4: operation code, defined in the package.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (low bits for SB/SH).
- `req_pc` in 32: PC of the instruction, used for trace only.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and exceptions.
- `resp_exc` out 1: alignment, range or illegal-op fault.
- `stall` out 1: high whenever the state is not IDLE.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read word.

## Operation
- Op codes: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7. Codes 8..15 are illegal.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `req_valid`, latch op, addr, wdata and pc.
  - Fault conditions: illegal op; LW/SW with `addr[1:0]!=0`; LH/LHU/SH with `addr[0]!=0`; or `addr[31:2] >= DEPTH_WORDS`.
  - On fault, go to DONE with the exception flag set and make no memory access. Otherwise go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_en=1`. `mem_we=1` for stores only.
  - Load wait counter with `MEM_LATENCY-1`.
  - Stores go to DONE; loads go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0, capture `mem_rdata` on the closing edge and go to DONE.
- **DONE**
  - `resp_valid=1` for one cycle, then go to IDLE.
  - `req_ready` stays low, so back-to-back requests are separated by at least one IDLE cycle.
- Store lanes:
  - SB: `mem_wdata={4{wdata[7:0]}}`, `mem_be=4'b0001<<addr[1:0]`.
  - SH: `mem_wdata={2{wdata[15:0]}}`, `mem_be = addr[1] ? 4'b1100 : 4'b0011`.
  - SW: `mem_wdata=wdata`, `mem_be=4'b1111`.
- Load extraction:
  - Byte: `rdata[8*addr[1:0] +: 8]`. Half: `rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `mem_en`, `mem_we` and `mem_be` are 0 outside ISSUE. `mem_addr` and `mem_wdata` hold the latched values.
- Simulation-only trace: in the ISSUE cycle of a store, print `@%h: *%h <= %h` with pc, `mem_addr` and `mem_wdata`.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `req_ready=1`, `stall=0`, `resp_valid=0`, `resp_rdata=0`, `resp_exc=0`.
  - All `mem_*` outputs 0.
- While `reset` is high, `mem_en`/`mem_we` are forced to 0 combinationally. An ISSUE cycle coinciding with reset performs no write.
- Latency from accept edge T (IDLE, `req_valid=1`):
  - Fault: `resp_valid` in cycle T+1.
  - Store: ISSUE in T+1, `resp_valid` in T+2.
  - Load: ISSUE in T+1, WAIT in T+2..T+1+MEM_LATENCY, `resp_valid` in T+2+MEM_LATENCY.
- Memory contract: `mem_rdata` must be valid throughout cycle T+1+MEM_LATENCY.
- `req_*` inputs are ignored outside IDLE. Changes after accept have no effect.
- `resp_rdata` and `resp_exc` are registered and valid only while `resp_valid` is high. They clear to 0 on return to IDLE.

## Structure
- Package `mips_mem_pkg` holds:
  - the op-code localparams and the state encoding;
  - the `is_load`/`is_store` and alignment-check functions.
- Sub-module `lsu_align` (combinational) generates `mem_be` and replicated `mem_wdata` from op and addr, and extracts and extends load data.
- `dm_lsu` holds the FSM, the latch registers, the wait counter and the trace.

## Test plan
- SW at addr 0x0000_0010, wdata 0x1234_5678 → ISSUE with `mem_be=4'hF`, `mem_addr=0x10`, `mem_we=1`; `resp_valid` two cycles after accept with `resp_exc=0`.
- SB at 0x0000_0013, wdata 0x0000_00AB → `mem_be=4'b1000`, `mem_wdata=0xABAB_ABAB`. Then LB and LBU at 0x13 with memory word 0xAB00_0000 → 0xFFFF_FFAB and 0x0000_00AB respectively.
- With MEM_LATENCY=3, LH at 0x2 and memory word 0x8001_7FFF → `resp_valid` exactly 5 cycles after accept, `resp_rdata=0xFFFF_8001`.
- LW at 0x6, SH at 0x1, op 9, and LW at 0x0000_3000 (word index 3072) → each gives `resp_exc=1` one cycle after accept, `mem_en` never asserted, `resp_rdata=0`.
- Assert reset during ISSUE of an SW → `mem_we=0` in that cycle; next cycle state IDLE, `stall=0`, `req_ready=1`, no `resp_valid` pulse.
